seg_scan_mux: RTL and testbench

- Time-multiplexing scanner for the board's 4-digit, common-anode 7-segment display.
- Sits directly upstream of the combinational hex-to-segment decoder.
- Holds a 16-bit display value and rotates through the 4 digits at a divided refresh rate.
- Each slot presents one 4-bit nibble to the decoder's x input and drives the active-low anode_L for that digit. Adds inter-digit ghost blanking and tear-free frame updates.

---
 rtl/seg_scan_pkg.sv | 25 ++
 rtl/seg_scan_mux_if.sv | 21 ++
 rtl/seg_tick_gen.sv | 26 ++
 rtl/seg_scan_mux.sv | 100 ++++++++++
 tb/tb_seg_scan_mux.sv | 148 ++++++++++++++
 5 files changed

// File: rtl/seg_scan_pkg.sv
// rtl/seg_scan_pkg.sv - shared types and constants for the 7-segment scanner
package seg_scan_pkg;

   localparam logic [3:0] ANODE_OFF  = 4'b1111;
   localparam int         NUM_DIGITS = 4;

   typedef enum logic {GUARD, SHOW} slot_state_t;

   typedef struct packed {
      logic [15:0] value;
      logic [3:0]  blank_mask;
      logic [3:0]  dp_mask;
   } disp_cfg_t;

   // True when digit i and every digit to its left hold zero; digit 0 is never blanked.
   function automatic logic lzb_blank(input logic [15:0] v, input logic [1:0] i);
      case (i)
         2'd1:    return (v[15:4] == 12'h000);
         2'd2:    return (v[15:8] == 8'h00);
         2'd3:    return (v[15:12] == 4'h0);
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/seg_scan_mux_if.sv
// rtl/seg_scan_mux_if.sv - display load inputs and scan outputs of seg_scan_mux
interface seg_scan_mux_if;
   logic [15:0] value;
   logic        load;
   logic [3:0]  blank_mask;
   logic [3:0]  dp_mask;
   logic [3:0]  digit_nib;
   logic [3:0]  anode_L;
   logic        dp_L;
   logic        frame_start;

   modport master (
      output value, load, blank_mask, dp_mask,
      input  digit_nib, anode_L, dp_L, frame_start
   );

   modport slave (
      input  value, load, blank_mask, dp_mask,
      output digit_nib, anode_L, dp_L, frame_start
   );
endinterface

// File: rtl/seg_tick_gen.sv
// rtl/seg_tick_gen.sv - prescaler producing a one-cycle tick every TICK_DIV clocks
module seg_tick_gen #(
   parameter int TICK_DIV = 100000,
   parameter int CNT_W    = 17
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst)
         cnt <= '0;
      else if (cnt == LAST)
         cnt <= '0;
      else
         cnt <= cnt + CNT_W'(1);
   end

   assign tick = (cnt == LAST);

endmodule

// File: rtl/seg_scan_mux.sv
// rtl/seg_scan_mux.sv - 4-digit 7-segment scanner with guard gap and frame double buffering
// Leading-zero blanking is built when SEG_SCAN_LZB_EN is defined.
module seg_scan_mux
   import seg_scan_pkg::*;
#(
   parameter int TICK_DIV = 100000,
   parameter int CNT_W    = 17
) (
   input logic           clk,
   input logic           rst,
   seg_scan_mux_if.slave bus
);

   logic                  tick;
   logic                  frame_tick;
   slot_state_t           state, state_nxt;
   logic [1:0]            idx;
   logic [1:0]            sel;
   logic                  blank;
   disp_cfg_t             pending, shadow, incoming;
   logic [3:0]            nib_q, nib_nxt;
   logic [NUM_DIGITS-1:0] anode_q, anode_nxt;
   logic                  dp_q, dp_nxt;
   logic                  fs_q, fs_nxt;

   seg_tick_gen #(.TICK_DIV(TICK_DIV), .CNT_W(CNT_W)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   assign incoming = '{value: bus.value, blank_mask: bus.blank_mask, dp_mask: bus.dp_mask};

   // idx has already advanced when GUARD runs, so the slot being prepared is idx-1;
   // the boundary is therefore the tick that moves idx off 0 into a fresh digit-0 slot.
   assign sel        = idx - 2'd1;
   assign frame_tick = tick && (idx == 2'd0);

`ifdef SEG_SCAN_LZB_EN
   assign blank = shadow.blank_mask[sel] | lzb_blank(shadow.value, sel);
`else
   assign blank = shadow.blank_mask[sel];
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= SHOW;
         idx     <= 2'd0;
         pending <= '0;
         shadow  <= '0;
         nib_q   <= 4'h0;
         anode_q <= ANODE_OFF;
         dp_q    <= 1'b1;
         fs_q    <= 1'b0;
      end else begin
         state   <= state_nxt;
         nib_q   <= nib_nxt;
         anode_q <= anode_nxt;
         dp_q    <= dp_nxt;
         fs_q    <= fs_nxt;
         if (tick)
            idx <= idx + 2'd1;
         if (bus.load)
            pending <= incoming;
         if (frame_tick)
            shadow <= bus.load ? incoming : pending;
      end
   end

   always_comb begin
      state_nxt = state;
      nib_nxt   = nib_q;
      anode_nxt = anode_q;
      dp_nxt    = dp_q;
      fs_nxt    = 1'b0;
      case (state)
         SHOW: begin
            if (tick) begin
               state_nxt = GUARD;
               anode_nxt = ANODE_OFF;
               dp_nxt    = 1'b1;
            end
         end
         GUARD: begin
            state_nxt = SHOW;
            nib_nxt   = shadow.value[{sel, 2'b00} +: 4];
            anode_nxt = blank ? ANODE_OFF : ~(4'b0001 << sel);
            dp_nxt    = ~(shadow.dp_mask[sel] & ~blank);
            fs_nxt    = (sel == 2'd0);
         end
         default: state_nxt = SHOW;
      endcase
   end

   assign bus.digit_nib   = nib_q;
   assign bus.anode_L     = anode_q;
   assign bus.dp_L        = dp_q;
   assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// tb/tb_seg_scan_mux.sv - self-checking bench for seg_scan_mux against a slot-timeline model
module tb_seg_scan_mux;
   import seg_scan_pkg::*;

   localparam int TD = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;

   seg_scan_mux_if bus();

   seg_scan_mux #(.TICK_DIV(TD), .CNT_W(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int        n_chk  = 0;
   int        n_pass = 0;
   int        m      = 0;
   disp_cfg_t latest;
   disp_cfg_t frames [0:255];

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s m=%0d observed=%h expected=%h", tag, m, obs, exp);
   endtask

   // Timeline: slot k ticks in cycle 4k+3, guard in 4k+4, shows in 4k+5..4k+7;
   // frame f (slots 4f..4f+3) uses the last load at or before cycle 16f+3.
   task automatic check_outputs();
      int        k, r, d;
      logic      blk;
      disp_cfg_t c;
      if (m < 5) begin
         chk("dark_anode", bus.anode_L, 4'hF);
         chk("dark_dp", {3'b000, bus.dp_L}, 4'h1);
         chk("dark_nib", bus.digit_nib, 4'h0);
         chk("dark_fs", {3'b000, bus.frame_start}, 4'h0);
      end else begin
         k = (m - 4) / 4;
         r = (m - 4) % 4;
         if (r == 0) begin
            chk("guard_anode", bus.anode_L, 4'hF);
            chk("guard_dp", {3'b000, bus.dp_L}, 4'h1);
            chk("guard_fs", {3'b000, bus.frame_start}, 4'h0);
         end else begin
            c   = frames[k / 4];
            d   = k % 4;
            blk = c.blank_mask[d];
`ifdef SEG_SCAN_LZB_EN
            if (d > 0 && (c.value >> (4 * d)) == 16'h0000)
               blk = 1'b1;
`endif
            chk("show_nib", bus.digit_nib, 4'((c.value >> (4 * d)) & 16'h000F));
            chk("show_anode", bus.anode_L, blk ? 4'hF : (4'hF ^ (4'd1 << d)));
            chk("show_dp", {3'b000, bus.dp_L}, {3'b000, !(c.dp_mask[d] && !blk)});
            chk("show_fs", {3'b000, bus.frame_start}, {3'b000, (r == 1 && d == 0)});
         end
      end
   endtask

   task automatic cyc(input logic ld, input logic [15:0] v, input logic [3:0] bm, input logic [3:0] dm);
      bus.load       = ld;
      bus.value      = v;
      bus.blank_mask = bm;
      bus.dp_mask    = dm;
      if (ld)
         latest = '{value: v, blank_mask: bm, dp_mask: dm};
      if (m % 16 == 3)
         frames[m / 16] = latest;
      @(posedge clk);
      @(negedge clk);
      m++;
      check_outputs();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         cyc(1'b0, 16'h0000, 4'h0, 4'h0);
   endtask

   task automatic idle_until(input int phase);
      for (int i = 0; i < 16 && (m % 16) != phase; i++)
         cyc(1'b0, 16'h0000, 4'h0, 4'h0);
   endtask

   task automatic do_reset(input int n);
      rst      = 1'b1;
      bus.load = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         @(negedge clk);
         m = 0;
         check_outputs();
      end
      rst    = 1'b0;
      m      = 0;
      latest = '0;
   endtask

   initial begin
      bus.load       = 1'b0;
      bus.value      = 16'h0000;
      bus.blank_mask = 4'h0;
      bus.dp_mask    = 4'h0;
      latest         = '0;
      for (int i = 0; i < 256; i++)
         frames[i] = '0;
      @(negedge clk);

      do_reset(3);
      idle(2);
      cyc(1'b1, 16'h1A2F, 4'h0, 4'h0);
      idle(36);

      cyc(1'b1, 16'h1234, 4'b1000, 4'b1001);
      idle_until(8);
      cyc(1'b1, 16'hBEEF, 4'h0, 4'h0);
      idle(34);

      idle_until(3);
      cyc(1'b1, 16'h5C07, 4'b0010, 4'b0110);
      idle(20);

      do_reset(2);
      idle_until(3);
      cyc(1'b1, 16'h0040, 4'h0, 4'b1111);
      idle(18);
      cyc(1'b1, 16'h0000, 4'h0, 4'b0001);
      idle(34);

      for (int i = 0; i < 500; i++) begin
         if ($urandom_range(0, 7) == 0)
            cyc(1'b1, 16'($urandom), 4'($urandom), 4'($urandom));
         else
            cyc(1'b0, 16'($urandom), 4'($urandom), 4'($urandom));
      end
      idle(20);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
